sample_pacer: RTL and testbench
===============================

Name: sample_pacer

Overview:
Producer-side block for the non-backpressurable sample/sample_valid interface consumed by the team's moving-average filter. It accepts bursty upstream words over a valid/ready handshake and buffers them in a flop FIFO of depth 2**D. It emits them as single-cycle sample_valid pulses at a programmable fixed interval. Underruns are flagged rather than stalled, because the consumer cannot be paused.

Parameters:
N, 16, bits per sample (matches the filter's N)
D, 2, FIFO depth is 2**D entries
W, 8, width of the interval field
PRIME_LEVEL, 2**D, FIFO occupancy required before emission starts; legal range 1..2**D

Ports:
clk  input  1  posedge clock
rstn  input  1  asynchronous, active-low reset
in_data  input  N  upstream sample word
in_valid  input  1  upstream word valid, active high
in_ready  output  1  FIFO can accept a word, active high
enable  input  1  run request, active high
interval  input  W  idle cycles between emission slots; 0 = one slot per cycle
clr_underrun  input  1  single-cycle pulse that clears the underrun flag
sample  output  N  paced sample to the filter
sample_valid  output  1  sample qualifier, one-cycle pulse, active high
underrun  output  1  sticky: a slot found the FIFO empty
level  output  D+1  current FIFO occupancy, 0..2**D

Behaviour:
- Clock and reset: one clock, clk. Reset is rstn, asynchronous and active-low.
- Reset state: FIFO empty, level=0, in_ready=1, sample=0, sample_valid=0, underrun=0, state=IDLE, slot counter cnt=0.
- FIFO storage: 2**D flops. Write and read pointers are D bits and wrap modulo 2**D. level is a separate (D+1)-bit counter.
- in_ready = (level != 2**D), combinational from registered level.
- Push occurs when in_valid && in_ready. A word pushed at cycle t is poppable no earlier than cycle t+1 (no fall-through).
- A push and a pop in the same cycle leave level unchanged. When full, in_ready=0, so no push occurs even if a pop happens that cycle.
- State IDLE:
  - No slots; cnt held at 0.
  - Pushes are still accepted.
  - Go to PRIME when enable=1.
- State PRIME:
  - No slots.
  - Go to RUN when level >= PRIME_LEVEL.
  - Go to IDLE when enable=0.
- State RUN:
  - slot = (cnt == 0).
  - On a slot: cnt <= interval, with interval sampled that cycle. Otherwise cnt <= cnt - 1.
  - Entering RUN forces cnt=0, so the first RUN cycle is a slot.
  - enable=0 returns to IDLE on the next cycle. The FIFO contents are retained and cnt is cleared.
- Slot with level > 0: pop the head entry. Next cycle, sample = popped word and sample_valid = 1.
- Slot with level == 0: no pop, sample_valid = 0 next cycle, underrun <= 1. The state stays RUN; the block does not re-prime.
- sample_valid is 1 only in the cycle after a successful slot. sample holds its last value otherwise.
- Spacing: consecutive valid pulses are exactly interval+1 cycles apart while data is available. Changing interval mid-run takes effect at the next slot reload.
- underrun stays set until a clr_underrun pulse. If clr_underrun and a new underrun event occur in the same cycle, set wins (underrun stays 1).
- Mid-operation reset: rstn assertion immediately forces the reset state. Buffered data is discarded.
- Throughput: with interval=0 and a continuous upstream, sustains one sample per cycle.

Test Plan:
- Priming and pacing (D=2, PRIME_LEVEL=4, interval=3): after reset, raise enable and push 0x0011, 0x0022, 0x0033, 0x0044 back to back. -> No sample_valid until level=4. Then sample_valid pulses carry 0x0011..0x0044 exactly 4 cycles apart. underrun stays 0.
- Underrun: continue the previous scenario with no further pushes. -> At the 5th slot sample_valid stays 0 and underrun=1, held through later cycles. A clr_underrun pulse then drops underrun to 0 next cycle.
- Full and backpressure: with enable=0, push 6 words holding in_valid high. -> The first 4 are accepted, then in_ready=0 and level=4. Words 5 and 6 are not consumed until slots free space after enable.
- Full throughput (interval=0, PRIME_LEVEL=1): drive a continuous in_valid stream of an incrementing count starting at 0x0100. -> sample_valid is high every cycle after start-up, samples are 0x0100, 0x0101, ... in order, with no gaps and no underrun.
- Enable drop and wrap: run with interval=1 until the pointers have wrapped at least twice, then drop enable mid-gap. -> Pulses stop within 1 cycle and level is preserved. On re-enable, emission resumes with the next in-order word, and ordering is correct across the wraps.
- Async reset mid-run: assert rstn low between clock edges while level=3 and sample_valid=1. -> sample_valid, sample, level and underrun go to 0 immediately and in_ready goes to 1. Output stays silent until the block is re-primed.

Source files
------------

// File: rtl/sample_pacer.sv
// Paces bursty upstream words out as evenly spaced single-cycle sample_valid pulses.
// A small flop FIFO absorbs bursts; slots that find it empty raise a sticky underrun flag.
module sample_pacer #(
    parameter int N           = 16,
    parameter int D           = 2,
    parameter int W           = 8,
    parameter int PRIME_LEVEL = 2**D
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         enable,
    input  logic [W-1:0] interval,
    input  logic         clr_underrun,
    output logic [N-1:0] sample,
    output logic         sample_valid,
    output logic         underrun,
    output logic [D:0]   level
);

    localparam int         DEPTH        = 2**D;
    localparam logic [D:0] FULL_LEVEL   = (D+1)'(DEPTH);
    localparam logic [D:0] PRIME_THRESH = (D+1)'(PRIME_LEVEL);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t         state, state_next;
    logic [W-1:0]   cnt, cnt_next;
    logic [N-1:0]   mem [DEPTH];
    logic [D-1:0]   wr_ptr, rd_ptr;
    logic           push, pop, slot, starved;

    assign in_ready = (level != FULL_LEVEL);
    assign push     = in_valid && in_ready;
    assign slot     = (state == RUN) && (cnt == '0);
    assign pop      = slot && (level != '0);
    assign starved  = slot && (level == '0);

    // cnt counts down idle cycles to the next slot; it is zero whenever not running
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        case (state)
            IDLE: begin
                if (enable) state_next = PRIME;
            end
            PRIME: begin
                if (!enable)                  state_next = IDLE;
                else if (level >= PRIME_THRESH) state_next = RUN;
            end
            RUN: begin
                if (!enable)   state_next = IDLE;
                else if (slot) cnt_next   = interval;
                else           cnt_next   = cnt - 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Storage needs no reset: the pointers and level define which entries are live
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // A fresh underrun takes priority over a simultaneous clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sample       <= '0;
            sample_valid <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            sample_valid <= pop;
            if (pop) sample <= mem[rd_ptr];
            if (starved)           underrun <= 1'b1;
            else if (clr_underrun) underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sample_pacer.sv
// Randomized and directed checks of sample_pacer against a queue-based reference model.
module tb_sample_pacer;

    localparam int N           = 16;
    localparam int D           = 2;
    localparam int W           = 8;
    localparam int DEPTH       = 2**D;
    localparam int PRIME_LEVEL = DEPTH;
    localparam int PH_IDLE = 0, PH_PRIME = 1, PH_RUN = 2;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [N-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         enable = 1'b0;
    logic [W-1:0] interval = '0;
    logic         clr_underrun = 1'b0;
    logic [N-1:0] sample;
    logic         sample_valid;
    logic         underrun;
    logic [D:0]   level;

    sample_pacer #(.N(N), .D(D), .W(W), .PRIME_LEVEL(PRIME_LEVEL)) dut (
        .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .enable(enable), .interval(interval),
        .clr_underrun(clr_underrun), .sample(sample), .sample_valid(sample_valid),
        .underrun(underrun), .level(level)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO contents as a queue, plus cycles remaining until the next slot
    logic [N-1:0] m_q[$];
    int           m_phase;
    int           m_wait;
    logic [N-1:0] m_sample;
    bit           m_valid;
    bit           m_under;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;
    bit last_accept;
    int spacing_gap = 0;
    int prev_pulse = -1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h at cycle %0d", tag, observed, expected, cycle);
        end
    endtask

    task automatic modelReset();
        m_q.delete();
        m_phase  = PH_IDLE;
        m_wait   = 0;
        m_sample = '0;
        m_valid  = 1'b0;
        m_under  = 1'b0;
    endtask

    task automatic modelStep();
        int size = m_q.size();
        bit is_slot = (m_phase == PH_RUN) && (m_wait == 0);
        last_accept = in_valid && (size != DEPTH);
        if (is_slot && size > 0) begin
            m_sample = m_q.pop_front();
            m_valid  = 1'b1;
        end else begin
            m_valid  = 1'b0;
        end
        if (is_slot && size == 0) m_under = 1'b1;
        else if (clr_underrun)    m_under = 1'b0;
        if (last_accept) m_q.push_back(in_data);
        case (m_phase)
            PH_IDLE: begin
                m_wait = 0;
                if (enable) m_phase = PH_PRIME;
            end
            PH_PRIME: begin
                m_wait = 0;
                if (!enable) m_phase = PH_IDLE;
                else if (size >= PRIME_LEVEL) m_phase = PH_RUN;
            end
            default: begin
                if (!enable) begin
                    m_phase = PH_IDLE;
                    m_wait  = 0;
                end else begin
                    m_wait = is_slot ? int'(interval) : m_wait - 1;
                end
            end
        endcase
    endtask

    // One clock: advance the model, let the edge pass, compare all outputs
    task automatic applyStimulus();
        modelStep();
        @(posedge clk);
        #1;
        cycle++;
        checkOutput("sample_valid", 32'(sample_valid), 32'(m_valid));
        checkOutput("sample", 32'(sample), 32'(m_sample));
        checkOutput("underrun", 32'(underrun), 32'(m_under));
        checkOutput("level", 32'(level), 32'(m_q.size()));
        checkOutput("in_ready", 32'(in_ready), 32'(m_q.size() != DEPTH));
        if (sample_valid === 1'b1) begin
            if (spacing_gap != 0 && prev_pulse >= 0)
                checkOutput("pulse_spacing", 32'(cycle - prev_pulse), 32'(spacing_gap));
            prev_pulse = cycle;
        end
    endtask

    task automatic doReset();
        in_valid = 1'b0;
        enable = 1'b0;
        clr_underrun = 1'b0;
        rstn = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_level", 32'(level), 32'd0);
        checkOutput("reset_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_valid", 32'(sample_valid), 32'd0);
        checkOutput("reset_sample", 32'(sample), 32'd0);
        checkOutput("reset_underrun", 32'(underrun), 32'd0);
        rstn = 1'b1;
    endtask

    initial begin
        int k;
        int pulses;
        int run_cycles;
        bit started;
        logic [N-1:0] words [6];
        logic [N-1:0] next_word;

        doReset();

        // Priming and pacing, then underrun once the four words are gone
        enable = 1'b1;
        interval = 8'd3;
        spacing_gap = 4;
        prev_pulse = -1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = N'((i + 1) * 16'h0011);
            applyStimulus();
        end
        in_valid = 1'b0;
        repeat (30) applyStimulus();
        spacing_gap = 0;
        checkOutput("underrun_held", 32'(underrun), 32'd1);
        enable = 1'b0;
        repeat (2) applyStimulus();
        clr_underrun = 1'b1;
        applyStimulus();
        clr_underrun = 1'b0;
        checkOutput("underrun_cleared", 32'(underrun), 32'd0);

        // Backpressure: six words offered while idle, only four fit
        for (int i = 0; i < 6; i++) words[i] = N'(16'h0A01 + i);
        interval = 8'd1;
        k = 0;
        repeat (8) begin
            in_valid = (k < 6);
            in_data  = words[k < 6 ? k : 5];
            applyStimulus();
            if (last_accept) k++;
        end
        checkOutput("bp_accepted", 32'(k), 32'd4);
        checkOutput("bp_level", 32'(level), 32'd4);
        enable = 1'b1;
        repeat (40) begin
            in_valid = (k < 6);
            in_data  = words[k < 6 ? k : 5];
            applyStimulus();
            if (last_accept) k++;
        end
        in_valid = 1'b0;
        checkOutput("bp_all_taken", 32'(k), 32'd6);

        // Random traffic: enable drops, interval changes, clears, many pointer wraps
        next_word = N'($urandom);
        for (int i = 0; i < 1500; i++) begin
            enable = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 9) == 0) interval = W'($urandom_range(0, 3));
            clr_underrun = ($urandom_range(0, 19) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            in_data  = next_word;
            applyStimulus();
            if (last_accept) next_word = N'($urandom);
        end
        clr_underrun = 1'b0;
        in_valid = 1'b0;

        // Full throughput with a continuous incrementing stream
        doReset();
        interval = 8'd0;
        enable = 1'b1;
        next_word = 16'h0100;
        pulses = 0;
        run_cycles = 0;
        started = 1'b0;
        spacing_gap = 1;
        prev_pulse = -1;
        repeat (60) begin
            in_valid = 1'b1;
            in_data  = next_word;
            applyStimulus();
            if (last_accept) next_word = next_word + 1'b1;
            if (sample_valid === 1'b1) started = 1'b1;
            if (started) begin
                run_cycles++;
                if (sample_valid === 1'b1) pulses++;
            end
        end
        spacing_gap = 0;
        in_valid = 1'b0;
        checkOutput("throughput", 32'(pulses), 32'(run_cycles));
        checkOutput("throughput_span", 32'(run_cycles > 40), 32'd1);

        // Asynchronous reset between edges while a pulse is out and level is 3
        doReset();
        enable = 1'b1;
        interval = 8'd3;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = N'(16'hB000 + i);
            applyStimulus();
        end
        in_valid = 1'b0;
        k = 0;
        while (!(m_valid && m_q.size() == 3) && k < 20) begin
            applyStimulus();
            k++;
        end
        checkOutput("reset_setup", 32'(sample_valid === 1'b1 && level == 3), 32'd1);
        #3;
        rstn = 1'b0;
        #1;
        modelReset();
        checkOutput("async_valid", 32'(sample_valid), 32'd0);
        checkOutput("async_sample", 32'(sample), 32'd0);
        checkOutput("async_level", 32'(level), 32'd0);
        checkOutput("async_underrun", 32'(underrun), 32'd0);
        checkOutput("async_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (12) applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule
